uart_tx_mmio: RTL and testbench
===============================

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Memory-mapped UART transmitter. The processor is the bus initiator; this block is the responder and drives the serial line.

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter TXDATA_ADDR, default 32'h4000_0018: address of the transmit data register.
REQ-003 Parameter STATUS_ADDR, default 32'h4000_001C: address of the status/control register.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 MemRead  input  1  bus read strobe.
REQ-007 MemWrite  input  1  bus write strobe, sampled at the rising edge.
REQ-008 Address  input  32  byte address; exact match required, no partial decode.
REQ-009 WriteData  input  32  bus write data.
REQ-010 ReadData  output  32  combinational read data.
REQ-011 tx  output  1  serial line, idle high.

Function
REQ-012 Word layout: 4-entry byte FIFO; count 0..4; full = (count==4); empty = (count==0).
REQ-013 Push: MemWrite with Address==TXDATA_ADDR pushes WriteData[7:0] when not full; upper bits are ignored.
REQ-014 Push when full with no pop in the same cycle is dropped and sets sticky overflow; FIFO contents and count are unchanged.
REQ-015 Push when full with a pop in the same cycle is accepted; count stays 4; overflow is not set.
REQ-016 Pop and push together with 0<count<4: the FIFO order is preserved and count is unchanged.
REQ-017 Write: MemWrite with Address==STATUS_ADDR and WriteData[3]==1 clears overflow. A push overflow in the same cycle wins, leaving overflow=1. Other bits are ignored.
REQ-018 Read: ReadData = {28'b0, overflow, empty, full, busy} when MemRead and Address==STATUS_ADDR.
REQ-019 Read: ReadData = {24'b0, head byte} when MemRead and Address==TXDATA_ADDR; the head byte is 0 when empty.
REQ-020 Read: otherwise ReadData = 0; reads have no side effects.
REQ-021 FSM states: IDLE, START, DATA, STOP; busy = (state != IDLE).
REQ-022 IDLE: tx=1; if the FIFO is not empty, pop the head into an 8-bit shift register, clear the baud counter and bit index, and go to START.
REQ-023 START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-024 DATA: send 8 bits LSB first, each for exactly CLKS_PER_BIT cycles; bit index 0..7; after bit 7 go to STOP.
REQ-025 STOP: tx=1 for exactly CLKS_PER_BIT cycles, then go to IDLE.
REQ-026 Timing: the baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
REQ-027 Latency: a write to an empty FIFO while the FSM is in IDLE is popped at the following edge, and tx falls one cycle after that pop edge (2 cycles after the write edge).
REQ-028 Frame spacing: back-to-back frames are separated by exactly one IDLE cycle with tx=1; a frame lasts 10*CLKS_PER_BIT cycles.
REQ-029 Glitch-free line: tx is driven from a register.
REQ-030 Frame integrity: a frame in progress is never altered by bus activity.

Reset
REQ-031 While reset=1 at an edge, the block enters or stays in IDLE and clears count, the FIFO pointers, overflow, the baud counter, the bit index and the shift register.
REQ-032 After reset, tx=1 and busy=0, full=0, empty=1, overflow=0; ReadData follows the REQ-018..020 decode.
REQ-033 Reset asserted mid-frame aborts the frame immediately; tx=1 from the cycle after the reset edge; buffered bytes are discarded.
REQ-034 A bus write in the same cycle as reset is ignored.

Verification (CLKS_PER_BIT=4)
REQ-035 Single byte: write 0x55 to TXDATA in IDLE -> tx falls at write edge+2 and then shows 0,1,0,1,0,1,0,1,0,1 in 4-cycle bits; busy=1 for 40 cycles; STATUS then reads 0x4.
REQ-036 Burst: 5 writes on consecutive cycles (0x01..0x05) -> all accepted (first pops immediately); frames 0x01..0x05 in order, one idle cycle between frames; overflow=0.
REQ-037 Overflow: 6 consecutive writes while a frame is in progress with 4 entries queued -> extra bytes dropped; STATUS reads 0xB (overflow|full|busy); writing 0x8 to STATUS clears overflow, and STATUS then reads 0x3.
REQ-038 Simultaneous push/pop at full: write exactly on the IDLE pop cycle with count=4 -> count stays 4, overflow=0, and byte order is preserved in the output.
REQ-039 Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> tx=1 the following cycle; STATUS reads 0x4; no further frames.
REQ-040 Decode: read unmapped address 0x4000_0014 and TXDATA when empty -> ReadData=0; write to an unmapped address -> no state change.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: 4-entry byte FIFO behind a data/status register
// pair, drained by an 8N1 serializer with a registered tx line.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] TXDATA_ADDR  = 32'h4000_0018,
  parameter logic [31:0] STATUS_ADDR  = 32'h4000_001C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        ovf_q, ovf_d;

  logic full, empty, busy;
  logic wr_tx, wr_st, pop, push_ok, drop, baud_end;
  logic [7:0] head;
  logic unused_wdata;

  assign full     = (count_q == 3'd4);
  assign empty    = (count_q == 3'd0);
  assign head     = mem_q[rd_ptr_q];
  assign wr_tx    = MemWrite && (Address == TXDATA_ADDR);
  assign wr_st    = MemWrite && (Address == STATUS_ADDR);
  assign pop      = (state_q == S_IDLE) && !empty;
  // A pop in the same cycle frees the slot, so a push at full still fits.
  assign push_ok  = wr_tx && (!full || pop);
  assign drop     = wr_tx && full && !pop;
  assign baud_end = (baud_q == BAUD_MAX);
  assign tx       = tx_q;
  assign unused_wdata = ^{WriteData[31:8], WriteData[7:4], WriteData[2:0]};

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!empty)                          state_d = S_START;
      S_START: if (baud_end)                        state_d = S_DATA;
      S_DATA:  if (baud_end && bit_idx_q == 3'd7)   state_d = S_STOP;
      S_STOP:  if (baud_end)                        state_d = S_IDLE;
      default:                                      state_d = S_IDLE;
    endcase
  end

  // Outputs; tx is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    busy = (state_q != S_IDLE);
    unique case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Baud counter, bit index and shift register.
  always_comb begin
    baud_d    = '0;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    if (state_q == S_IDLE) begin
      bit_idx_d = '0;
      if (pop) shreg_d = head;
    end else begin
      baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
      if (state_q == S_DATA && baud_end) begin
        bit_idx_d = bit_idx_q + 3'd1;
        shreg_d   = {1'b0, shreg_q[7:1]};
      end
    end
  end

  // FIFO and sticky overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {2'b00, push_ok} - {2'b00, pop};
    ovf_d    = ovf_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = WriteData[7:0];
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (drop)                    ovf_d = 1'b1;
    else if (wr_st && WriteData[3]) ovf_d = 1'b0;
  end

  // Read decode is side-effect free.
  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      if (Address == STATUS_ADDR)
        ReadData = {28'b0, ovf_q, empty, full, busy};
      else if (Address == TXDATA_ADDR)
        ReadData = {24'b0, (empty ? 8'h00 : head)};
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_uart_tx_mmio;
  localparam int N = 4;
  localparam logic [31:0] TXA = 32'h4000_0018;
  localparam logic [31:0] STA = 32'h4000_001C;
  localparam logic [31:0] UNM = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset, MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;
  logic        tx;

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  uart_tx_mmio #(.CLKS_PER_BIT(N), .TXDATA_ADDR(TXA), .STATUS_ADDR(STA)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .tx(tx)
  );

  // Reference model: a queue of pending bytes and a cycle offset within the current frame.
  logic [7:0] q [$];
  bit         m_busy = 0;
  int         m_t    = 0;
  logic [7:0] m_cur  = 0;
  bit         m_ovf  = 0;
  logic       m_txe  = 1'b1;

  function automatic logic frame_bit(logic [7:0] b, int t);
    int k;
    k = t / N;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd();
    if (!MemRead) return 32'h0;
    if (Address == STA)
      return {28'b0, m_ovf, (q.size() == 0), (q.size() == 4), m_busy};
    if (Address == TXA)
      return (q.size() != 0) ? {24'b0, q[0]} : 32'h0;
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    bit full_pre, pop, psh, ovf_set;
    if (reset) begin
      q.delete();
      m_busy = 0; m_t = 0; m_ovf = 0; m_txe = 1'b1; m_cur = 0;
    end else begin
      m_txe    = m_busy ? frame_bit(m_cur, m_t) : 1'b1;
      full_pre = (q.size() == 4);
      pop      = !m_busy && (q.size() != 0);
      if (m_busy) begin
        m_t++;
        if (m_t == 10 * N) m_busy = 0;
      end
      if (pop) begin
        m_cur = q.pop_front();
        m_busy = 1; m_t = 0;
      end
      psh     = MemWrite && (Address == TXA);
      ovf_set = psh && full_pre && !pop;
      if (psh && !ovf_set) q.push_back(WriteData[7:0]);
      if (ovf_set) m_ovf = 1;
      else if (MemWrite && Address == STA && WriteData[3]) m_ovf = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++; bad++;
    $display("FAIL %s: wait expired at %0t", nm, $time);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("tx", {31'b0, tx}, {31'b0, m_txe});
      chk("rdata", ReadData, exp_rd());
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Address = a; WriteData = d;
    step();
    MemWrite = 1'b0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
    MemRead = 1'b1; Address = a;
    @(negedge clk);
    chk(nm, ReadData, exp);
    step();
    MemRead = 1'b0;
  endtask

  task automatic wait_drained(input string nm);
    int n = 0;
    while ((m_busy || q.size() != 0) && n < 2000) begin step(); n++; end
    if (n >= 2000) timeout(nm);
    step();
  endtask

  initial begin
    logic [9:0] pat;
    int n;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    repeat (3) step();
    reset = 1'b0;
    armed = 1;

    // Reset state
    @(negedge clk);
    chk("reset_tx", {31'b0, tx}, 32'h1);
    step();
    rd_chk(STA, 32'h4, "reset_status");

    // Single byte 0x55: tx low two edges after the write, then 0,1,0,1,... per 4-cycle bit
    pat = 10'b1010101010;
    wr(TXA, 32'hFFFF_FF55);
    @(negedge clk); chk("lat_a", {31'b0, tx}, 32'h1);
    @(negedge clk); chk("lat_b", {31'b0, tx}, 32'h1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("frame55_%0d", i), {31'b0, tx}, {31'b0, pat[i/N]});
    end
    step();
    rd_chk(STA, 32'h4, "single_status");

    // Burst of 5 consecutive writes, all accepted
    for (int i = 1; i <= 5; i++) wr(TXA, i);
    rd_chk(STA, 32'h3, "burst_status");
    wait_drained("burst_drain");
    rd_chk(STA, 32'h4, "burst_done_status");

    // Overflow while a frame is in progress
    wr(TXA, 32'hA0);
    step(); step();
    for (int i = 1; i <= 6; i++) wr(TXA, 32'hA0 + i);
    rd_chk(STA, 32'hB, "ovf_status");
    wr(STA, 32'h8);
    rd_chk(STA, 32'h3, "ovf_clear_status");

    // Push on the exact IDLE pop cycle with the FIFO full
    n = 0;
    while (!(!m_busy && q.size() == 4) && n < 200) begin step(); n++; end
    if (n >= 200) timeout("full_pop_wait");
    wr(TXA, 32'hC5);
    rd_chk(STA, 32'h3, "push_pop_full_status");
    wait_drained("push_pop_drain");

    // Reset during data bit 3 with two bytes queued; a same-cycle write is ignored
    wr(TXA, 32'h3C); wr(TXA, 32'h11); wr(TXA, 32'h22);
    n = 0;
    while (!(m_busy && m_t == 5 * N - 3) && n < 200) begin step(); n++; end
    if (n >= 200) timeout("bit3_wait");
    reset = 1'b1; MemWrite = 1'b1; Address = TXA; WriteData = 32'h77;
    step();
    reset = 1'b0; MemWrite = 1'b0;
    @(negedge clk); chk("abort_tx", {31'b0, tx}, 32'h1);
    step();
    rd_chk(STA, 32'h4, "abort_status");
    repeat (60) step();
    @(negedge clk); chk("abort_quiet_tx", {31'b0, tx}, 32'h1);
    step();

    // Decode
    rd_chk(UNM, 32'h0, "unmapped_read");
    rd_chk(TXA, 32'h0, "txdata_empty_read");
    wr(UNM, 32'hFF);
    rd_chk(STA, 32'h4, "unmapped_write_status");

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int a;
      reset     = ($urandom_range(0, 399) == 0);
      MemWrite  = ($urandom_range(0, 2) == 0);
      MemRead   = $urandom_range(0, 1) != 0;
      WriteData = $urandom;
      a = $urandom_range(0, 4);
      case (a)
        0, 1:    Address = TXA;
        2:       Address = STA;
        3:       Address = UNM;
        default: Address = $urandom;
      endcase
      step();
    end
    reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
